// File: rtl/conv_pool_stage_if.sv
// Handshake bundle between the conv engine, the pooling stage and its consumers.
// The slave modport is the pooling stage; the master modport is the surrounding logic.
interface conv_pool_stage_if #(
  parameter int unsigned N_IN  = 30,
  parameter int unsigned IN_W  = 18,
  parameter int unsigned OUT_W = 8
);
  localparam int unsigned IDX_W = (N_IN / 2 > 1) ? $clog2(N_IN / 2) : 1;

  logic                       in_valid;
  logic [N_IN-1:0][IN_W-1:0]  in_data;
  logic                       in_ready;
  logic                       overrun;
  logic                       out_valid;
  logic                       out_ready;
  logic [OUT_W-1:0]           out_data;
  logic [IDX_W-1:0]           out_index;
  logic                       out_last;
  logic                       peak_valid;
  logic [OUT_W-1:0]           peak_value;
  logic [IDX_W-1:0]           peak_index;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, overrun, out_valid, out_data, out_index, out_last,
           peak_valid, peak_value, peak_index
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, overrun, out_valid, out_data, out_index, out_last,
           peak_valid, peak_value, peak_index
  );
endinterface

// File: rtl/conv_pool_stage.sv
// Captures one row of conv results, applies ReLU/shift/saturate, 2:1 max-pools and streams
// the pooled values out, then reports the row peak (first occurrence) as a one-cycle pulse.
module conv_pool_stage #(
  parameter int unsigned N_IN  = 30,
  parameter int unsigned IN_W  = 18,
  parameter int unsigned OUT_W = 8,
  parameter int unsigned SHIFT = 2
) (
  input  logic             clk,
  input  logic             rst,
  conv_pool_stage_if.slave bus
);
  localparam int unsigned HALF  = N_IN / 2;
  localparam int unsigned IDX_W = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(HALF - 1);

  typedef enum logic [1:0] {IDLE, FETCH, STREAM, REPORT} state_t;

  state_t                  state_q;
  logic signed [IN_W-1:0]  buf_q [N_IN];
  logic                    in_ready_q;
  logic                    overrun_q;
  logic                    out_valid_q;
  logic [OUT_W-1:0]        out_data_q;
  logic [IDX_W-1:0]        out_index_q;
  logic                    out_last_q;
  logic                    peak_valid_q;
  logic [OUT_W-1:0]        peak_value_q;
  logic [IDX_W-1:0]        peak_index_q;

  logic [IDX_W-1:0]        sel;
  logic [OUT_W-1:0]        s_a, s_b, pool_next;

  function automatic logic [OUT_W-1:0] relu_sat(input logic signed [IN_W-1:0] x);
    logic signed [IN_W-1:0] r;
    r = x >>> SHIFT;
    if (x[IN_W-1]) return '0;
    if (r[IN_W-1:OUT_W] != '0) return '1;
    return r[OUT_W-1:0];
  endfunction

  // Pair selected for loading: pair 0 in FETCH, the following pair while streaming.
  always_comb begin
    sel = '0;
    if (state_q == STREAM && out_index_q != LAST_IDX) sel = out_index_q + 1'b1;
    s_a       = relu_sat(buf_q[{sel, 1'b0}]);
    s_b       = relu_sat(buf_q[{sel, 1'b1}]);
    pool_next = (s_a > s_b) ? s_a : s_b;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      for (int unsigned i = 0; i < N_IN; i++) buf_q[i] <= '0;
      in_ready_q   <= 1'b1;
      overrun_q    <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_index_q  <= '0;
      out_last_q   <= 1'b0;
      peak_valid_q <= 1'b0;
      peak_value_q <= '0;
      peak_index_q <= '0;
    end else begin
      overrun_q    <= bus.in_valid && (state_q != IDLE);
      peak_valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            for (int unsigned i = 0; i < N_IN; i++) buf_q[i] <= bus.in_data[i];
            out_index_q  <= '0;
            peak_value_q <= '0;
            peak_index_q <= '0;
            in_ready_q   <= 1'b0;
            state_q      <= FETCH;
          end
        end
        FETCH: begin
          out_data_q  <= pool_next;
          out_index_q <= '0;
          out_last_q  <= (LAST_IDX == '0);
          out_valid_q <= 1'b1;
          state_q     <= STREAM;
        end
        STREAM: begin
          if (out_valid_q && bus.out_ready) begin
            if (out_data_q > peak_value_q) begin
              peak_value_q <= out_data_q;
              peak_index_q <= out_index_q;
            end
            if (out_last_q) begin
              out_valid_q  <= 1'b0;
              out_last_q   <= 1'b0;
              peak_valid_q <= 1'b1;
              state_q      <= REPORT;
            end else begin
              out_data_q  <= pool_next;
              out_index_q <= sel;
              out_last_q  <= (sel == LAST_IDX);
            end
          end
        end
        REPORT: begin
          in_ready_q <= 1'b1;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.overrun    = overrun_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_index  = out_index_q;
  assign bus.out_last   = out_last_q;
  assign bus.peak_valid = peak_valid_q;
  assign bus.peak_value = peak_value_q;
  assign bus.peak_index = peak_index_q;
endmodule

// File: tb/tb_conv_pool_stage.sv
// Randomized bench for conv_pool_stage: rows go through an arithmetic reference model
// and every streamed value, index, last flag, peak and timing point is compared.
module tb_conv_pool_stage;
  localparam int N_IN  = 30;
  localparam int IN_W  = 18;
  localparam int OUT_W = 8;
  localparam int SHIFT = 2;
  localparam int HALF  = N_IN / 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  conv_pool_stage_if #(.N_IN(N_IN), .IN_W(IN_W), .OUT_W(OUT_W)) bus ();

  conv_pool_stage #(.N_IN(N_IN), .IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int row_q [N_IN];
  int exp_q [HALF];

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int ref_sat(input int x);
    int q;
    if (x <= 0) return 0;
    q = x / (1 << SHIFT);
    return (q > (1 << OUT_W) - 1) ? (1 << OUT_W) - 1 : q;
  endfunction

  task automatic build_expect(output int pk, output int pki);
    int a, b;
    pk = 0;
    pki = 0;
    for (int k = 0; k < HALF; k++) begin
      a = ref_sat(row_q[2*k]);
      b = ref_sat(row_q[2*k+1]);
      exp_q[k] = (a > b) ? a : b;
      if (exp_q[k] > pk) begin
        pk = exp_q[k];
        pki = k;
      end
    end
  endtask

  // mode 0: out_ready always high, 1: fixed 1,0,0,1,0,1 pattern, 2: random
  task automatic run_row(input int mode, input bit pulses, input int abort_after);
    int pk, pki, hs, first_n, pv_n, pat;
    bit prev_stall, prev_iv, done, rdy, iv;
    int prev_data, prev_idx;
    bit [5:0] stall_pattern;
    stall_pattern = 6'b101001;
    hs = 0; first_n = -1; pv_n = -1; pat = 0;
    prev_stall = 0; prev_iv = 0; done = 0; prev_data = 0; prev_idx = 0;
    build_expect(pk, pki);
    @(negedge clk);
    check_eq("idle_ready", bus.in_ready, 1);
    for (int i = 0; i < N_IN; i++) bus.in_data[i] = IN_W'(row_q[i]);
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    for (int n = 1; n <= 400 && !done; n++) begin
      if (n > 1) @(negedge clk);
      if (abort_after > 0 && hs == abort_after) begin
        rst = 1'b0;
        #1;
        check_eq("rst_out_valid", bus.out_valid, 0);
        check_eq("rst_peak_valid", bus.peak_valid, 0);
        check_eq("rst_in_ready", bus.in_ready, 1);
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        return;
      end
      check_eq("overrun", bus.overrun, prev_iv);
      if (prev_stall) begin
        check_eq("stall_data", bus.out_data, prev_data);
        check_eq("stall_index", bus.out_index, prev_idx);
      end
      if (bus.out_valid && first_n < 0) begin
        first_n = n;
        check_eq("first_valid_cycle", n, 2);
      end
      if (pv_n > 0) begin
        check_eq("peak_pulse_width", bus.peak_valid, 0);
        check_eq("ready_after_report", bus.in_ready, 1);
        done = 1;
      end else if (bus.peak_valid) begin
        pv_n = n;
        check_eq("peak_value", bus.peak_value, pk);
        check_eq("peak_index", bus.peak_index, pki);
        check_eq("handshakes_at_peak", hs, HALF);
        if (mode == 0) check_eq("peak_cycle", n, HALF + 2);
      end
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = stall_pattern[pat % 6];
        default: rdy = 1'($urandom % 2);
      endcase
      pat++;
      bus.out_ready = rdy;
      if (bus.out_valid && rdy) begin
        if (hs < HALF) begin
          check_eq("out_data", bus.out_data, exp_q[hs]);
          check_eq("out_index", bus.out_index, hs);
          check_eq("out_last", bus.out_last, (hs == HALF - 1) ? 1 : 0);
        end else begin
          check_eq("extra_output", hs, HALF - 1);
        end
        hs++;
      end
      prev_stall = bus.out_valid && !rdy;
      prev_data = bus.out_data;
      prev_idx = bus.out_index;
      iv = pulses && hs >= 1 && hs < 12 && ($urandom % 3 == 0);
      if (iv) for (int i = 0; i < N_IN; i++) bus.in_data[i] = IN_W'($urandom);
      bus.in_valid = iv;
      prev_iv = iv;
    end
    if (!done) check_eq("timeout", 0, 1);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
  endtask

  task automatic fill_random_row();
    for (int i = 0; i < N_IN; i++) begin
      case ($urandom % 4)
        0:       row_q[i] = int'($urandom_range(1000, 1100));
        1:       row_q[i] = -int'($urandom_range(1, 131072));
        2:       row_q[i] = int'($urandom_range(0, 262143)) - 131072;
        default: row_q[i] = int'($urandom_range(0, 40));
      endcase
    end
  endtask

  task automatic fill_ramp();
    for (int i = 0; i < N_IN; i++) row_q[i] = 8 * i;
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_data = '0;
    #12;
    check_eq("reset_in_ready", bus.in_ready, 1);
    check_eq("reset_out_valid", bus.out_valid, 0);
    check_eq("reset_peak_valid", bus.peak_valid, 0);
    check_eq("reset_overrun", bus.overrun, 0);
    check_eq("reset_out_data", bus.out_data, 0);
    check_eq("reset_out_last", bus.out_last, 0);
    check_eq("reset_peak_value", bus.peak_value, 0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < N_IN; i++) row_q[i] = 0;
    run_row(0, 0, 0);

    fill_ramp();
    run_row(0, 0, 0);
    check_eq("ramp_peak_hold", bus.peak_value, 58);

    for (int i = 0; i < N_IN; i++) row_q[i] = -100;
    row_q[5] = 2000;
    row_q[20] = 1020;
    run_row(0, 0, 0);

    fill_ramp();
    run_row(1, 0, 0);

    fill_random_row();
    run_row(2, 1, 0);

    fill_ramp();
    run_row(0, 0, 5);
    fill_ramp();
    run_row(0, 0, 0);

    for (int r = 0; r < 8; r++) begin
      fill_random_row();
      run_row(r % 3, r[0], 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
